// File: rtl/proc_pkg.sv
// proc_pkg: latencies, register ids and pipe selector shared by the issue scoreboard
package proc_pkg;
  localparam int SCALAR_LAT = 3;
  localparam int VECTOR_LAT = 9;
  typedef struct packed {
    logic       file;
    logic [4:0] addr;
  } reg_id_t;
  typedef enum logic {
    PIPE_SCALAR = 1'b0,
    PIPE_VECTOR = 1'b1
  } pipe_sel_t;
endpackage

// File: rtl/wb_slot_ring.sv
// wb_slot_ring: one RF write port's reservation ring, bit k = writeback k cycles ahead
module wb_slot_ring (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_i,
  input  logic [3:0]  slot_i,
  output logic [15:0] ring_o,
  output logic        due_o
);
  logic [15:0] ring_q, ring_d;
  always_comb ring_d = (ring_q >> 1) | (16'(set_i) << slot_i);
  always_ff @(posedge clk) ring_q <= !rst_n ? '0 : ring_d;
  assign ring_o = ring_q;
  assign due_o  = ring_q[0];
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdowns plus write-port rings deciding when decode may issue
module hazard_scoreboard #(
  parameter int SCALAR_LAT = proc_pkg::SCALAR_LAT,
  parameter int VECTOR_LAT = proc_pkg::VECTOR_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              issue_pipe,
  input  logic              src1_en,
  input  logic              src2_en,
  input  logic              dst_en,
  input  proc_pkg::reg_id_t src1,
  input  proc_pkg::reg_id_t src2,
  input  proc_pkg::reg_id_t dst,
  output logic              issue_stall,
  output logic              issue_fire,
  output logic              wb_due_s,
  output logic              wb_due_v,
  output logic [6:0]        inflight,
  output logic              idle
);
  import proc_pkg::*;
  localparam logic [3:0] LS = 4'(SCALAR_LAT);
  localparam logic [3:0] LV = 4'(VECTOR_LAT);
  logic [3:0]  cnt_q [64];
  logic [3:0]  cnt_d [64];
  logic [6:0]  inflight_q, inflight_d;
  logic [15:0] ring_s, ring_v;
  logic [3:0]  lat;
  logic [1:0]  n_ret;
  logic        raw, waw, port_taken, wr;
  assign lat = pipe_sel_t'(issue_pipe) == PIPE_VECTOR ? LV : LS;
  // a count of 1 means the write lands this cycle, so the value is already readable/overwritable
  always_comb begin
    raw         = (src1_en && cnt_q[src1] > 4'd1) || (src2_en && cnt_q[src2] > 4'd1);
    waw         = dst_en && cnt_q[dst] > 4'd1;
    port_taken  = dst_en && (dst.file ? ring_v[lat] : ring_s[lat]);
    issue_stall = issue_valid && (raw || waw || port_taken);
  end
  assign issue_fire = issue_valid && !issue_stall;
  assign wr         = issue_fire && dst_en;
  always_comb begin
    n_ret = '0;
    for (int i = 0; i < 64; i++) begin
      cnt_d[i] = cnt_q[i] != 4'd0 ? cnt_q[i] - 4'd1 : 4'd0;
      n_ret    = n_ret + 2'(cnt_q[i] == 4'd1);
    end
    if (wr) cnt_d[dst] = lat;
    inflight_d = inflight_q + 7'(wr) - 7'(n_ret);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '{default: '0};
      inflight_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end
  wb_slot_ring u_ring_s (
    .clk   (clk),
    .rst_n (rst_n),
    .set_i (wr && !dst.file),
    .slot_i(lat - 4'd1),
    .ring_o(ring_s),
    .due_o (wb_due_s)
  );
  wb_slot_ring u_ring_v (
    .clk   (clk),
    .rst_n (rst_n),
    .set_i (wr && dst.file),
    .slot_i(lat - 4'd1),
    .ring_o(ring_v),
    .due_o (wb_due_v)
  );
  assign inflight = inflight_q;
  assign idle     = inflight_q == 7'd0;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed hazard scenarios plus a time-stamped reference model on a random stream
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid, issue_pipe, src1_en, src2_en, dst_en;
  logic [5:0] src1, src2, dst;
  logic       issue_stall, issue_fire, wb_due_s, wb_due_v, idle;
  logic [6:0] inflight;
  int         n_chk = 0;
  int         n_err = 0;
  int         wbt [64];
  bit         res [2][32];
  always #5 clk = ~clk;
  hazard_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_valid),
    .issue_pipe (issue_pipe),
    .src1_en    (src1_en),
    .src2_en    (src2_en),
    .dst_en     (dst_en),
    .src1       (src1),
    .src2       (src2),
    .dst        (dst),
    .issue_stall(issue_stall),
    .issue_fire (issue_fire),
    .wb_due_s   (wb_due_s),
    .wb_due_v   (wb_due_v),
    .inflight   (inflight),
    .idle       (idle)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic v, input logic p, input logic [5:0] a, input logic [5:0] b,
                     input logic [5:0] d, input logic ae, input logic be, input logic de);
    issue_valid = v; issue_pipe = p; src1 = a; src2 = b; dst = d;
    src1_en = ae; src2_en = be; dst_en = de;
    #1;
  endtask
  task automatic nop();
    drv(0, 0, 6'h00, 6'h00, 6'h00, 0, 0, 0);
  endtask
  initial begin
    int L, exp_inf;
    logic v, p, ae, be, de, es;
    logic [5:0] a, b, d;
    nop();
    cyc(); cyc();
    chk("rst_stall", issue_stall, 0);
    chk("rst_fire", issue_fire, 0);
    chk("rst_wb_s", wb_due_s, 0);
    chk("rst_wb_v", wb_due_v, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_idle", idle, 1);
    rst_n = 1'b1;
    cyc();
    // scalar RAW on s5
    drv(1, 0, 6'h00, 6'h00, 6'h05, 0, 0, 1);
    chk("raw_fire0", issue_fire, 1);
    cyc();
    for (int t = 1; t <= 2; t++) begin
      drv(1, 0, 6'h05, 6'h00, 6'h00, 1, 0, 0);
      chk("raw_stall", issue_stall, 1);
      chk("raw_inflight", inflight, 1);
      cyc();
    end
    drv(1, 0, 6'h05, 6'h00, 6'h00, 1, 0, 0);
    chk("raw_fire3", issue_fire, 1);
    chk("raw_wb3", wb_due_s, 1);
    cyc();
    nop();
    repeat (16) cyc();
    chk("raw_idle", idle, 1);
    // vector long latency on v2
    drv(1, 1, 6'h00, 6'h00, 6'h22, 0, 0, 1);
    chk("vec_fire0", issue_fire, 1);
    cyc();
    for (int t = 1; t <= 8; t++) begin
      drv(1, 0, 6'h00, 6'h22, 6'h00, 0, 1, 0);
      chk("vec_stall", issue_stall, 1);
      chk("vec_inflight", inflight, 1);
      chk("vec_wb_early", wb_due_v, 0);
      cyc();
    end
    drv(1, 0, 6'h00, 6'h22, 6'h00, 0, 1, 0);
    chk("vec_fire9", issue_fire, 1);
    chk("vec_wb9", wb_due_v, 1);
    cyc();
    nop();
    chk("vec_inflight10", inflight, 0);
    repeat (16) cyc();
    // scalar write port conflict between vector-pipe s1 and scalar-pipe s3
    drv(1, 1, 6'h00, 6'h00, 6'h01, 0, 0, 1);
    chk("port_fire0", issue_fire, 1);
    cyc();
    nop();
    repeat (5) cyc();
    drv(1, 0, 6'h00, 6'h00, 6'h03, 0, 0, 1);
    chk("port_stall6", issue_stall, 1);
    cyc();
    drv(1, 0, 6'h00, 6'h00, 6'h03, 0, 0, 1);
    chk("port_fire7", issue_fire, 1);
    cyc();
    nop();
    chk("port_wb8", wb_due_s, 0);
    chk("port_inflight8", inflight, 2);
    cyc();
    chk("port_wb9", wb_due_s, 1);
    chk("port_wbv9", wb_due_v, 0);
    cyc();
    chk("port_wb10", wb_due_s, 1);
    cyc();
    repeat (16) cyc();
    // WAW on s4 with refire in the retire cycle
    drv(1, 0, 6'h00, 6'h00, 6'h04, 0, 0, 1);
    chk("waw_fire0", issue_fire, 1);
    cyc();
    for (int t = 1; t <= 2; t++) begin
      drv(1, 0, 6'h00, 6'h00, 6'h04, 0, 0, 1);
      chk("waw_stall", issue_stall, 1);
      cyc();
    end
    drv(1, 0, 6'h00, 6'h00, 6'h04, 0, 0, 1);
    chk("waw_fire3", issue_fire, 1);
    chk("waw_wb3", wb_due_s, 1);
    chk("waw_inflight3", inflight, 1);
    cyc();
    nop();
    chk("waw_inflight4", inflight, 1);
    chk("waw_wb4", wb_due_s, 0);
    cyc(); cyc();
    chk("waw_wb6", wb_due_s, 1);
    cyc();
    drv(1, 0, 6'h07, 6'h00, 6'h07, 1, 0, 1);
    chk("self_dep_fire", issue_fire, 1);
    cyc();
    drv(0, 0, 6'h07, 6'h00, 6'h00, 1, 0, 0);
    chk("novalid_stall", issue_stall, 0);
    chk("novalid_fire", issue_fire, 0);
    chk("novalid_inflight", inflight, 1);
    cyc();
    nop();
    repeat (16) cyc();
    // reset with three writes in flight
    drv(1, 0, 6'h00, 6'h00, 6'h0A, 0, 0, 1);
    chk("mid_fire_a", issue_fire, 1);
    cyc();
    drv(1, 1, 6'h00, 6'h00, 6'h2B, 0, 0, 1);
    chk("mid_fire_b", issue_fire, 1);
    cyc();
    drv(1, 1, 6'h00, 6'h00, 6'h0C, 0, 0, 1);
    chk("mid_fire_c", issue_fire, 1);
    cyc();
    nop();
    chk("mid_inflight", inflight, 3);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_idle", idle, 1);
    chk("mid_inflight0", inflight, 0);
    for (int t = 0; t < 16; t++) begin
      chk("mid_wb_s", wb_due_s, 0);
      chk("mid_wb_v", wb_due_v, 0);
      cyc();
    end
    drv(1, 0, 6'h2B, 6'h0C, 6'h0A, 1, 1, 1);
    chk("mid_stall_clear", issue_stall, 0);
    chk("mid_fire_after", issue_fire, 1);
    cyc();
    nop();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    // random stream against an absolute-time model of writebacks
    foreach (wbt[i]) wbt[i] = 0;
    foreach (res[f, s]) res[f][s] = 1'b0;
    for (int c = 1; c <= 10000; c++) begin
      v  = $urandom_range(3, 0) != 0;
      p  = 1'($urandom);
      a  = {1'($urandom), 3'b000, 2'($urandom)};
      b  = {1'($urandom), 3'b000, 2'($urandom)};
      d  = {1'($urandom), 3'b000, 2'($urandom)};
      ae = 1'($urandom);
      be = 1'($urandom);
      de = 1'($urandom);
      drv(v, p, a, b, d, ae, be, de);
      L = p ? 9 : 3;
      es = v && ((ae && wbt[a] > c) || (be && wbt[b] > c) ||
                 (de && (wbt[d] > c || res[d[5]][(c + L) % 32])));
      exp_inf = 0;
      for (int i = 0; i < 64; i++) if (wbt[i] >= c) exp_inf++;
      chk("rnd_stall", issue_stall, es);
      chk("rnd_fire", issue_fire, v && !es);
      chk("rnd_wb_s", wb_due_s, res[0][c % 32]);
      chk("rnd_wb_v", wb_due_v, res[1][c % 32]);
      chk("rnd_inflight", inflight, exp_inf);
      if (v && !es && de) begin
        wbt[d] = c + L;
        res[d[5]][(c + L) % 32] = 1'b1;
      end
      res[0][c % 32] = 1'b0;
      res[1][c % 32] = 1'b0;
      cyc();
    end
    nop();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
